// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core MEM stage (port 0) vs loader/debug (port 1) with bus lock.
// Optional macro DMEM_ARB_RR_EN selects round-robin conflict resolution; default is fixed priority to port 0.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [2:0]            p0_funct3,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_stall,
    output logic                  p0_rvalid,
    output logic                  p0_err,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic                  p1_lock,
    input  logic [2:0]            p1_funct3,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic                  p1_err,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    localparam logic [2:0] LOCK_LIMIT = 3'd7;

    state_t                state_q, state_d;
    logic [2:0]            lock_cnt_q, lock_cnt_d;
    logic                  gnt0, gnt1, any_gnt, p0_wins;
    logic                  sel_we, misaligned;
    logic [2:0]            sel_funct3;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata, resp_data;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  p0_rvalid_q, p0_err_q, p1_rvalid_q, p1_err_q;
    logic [DATA_WIDTH-1:0] p0_rdata_q, p1_rdata_q;

`ifdef DMEM_ARB_RR_EN
    // High when port 1 holds the most recent grant; reset value favours port 0.
    logic last_gnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else if (gnt1) begin
            last_gnt_q <= 1'b1;
        end else if (gnt0) begin
            last_gnt_q <= 1'b0;
        end
    end

    assign p0_wins = last_gnt_q;
`else
    assign p0_wins = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            lock_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Grant decision, lock entry/exit and starvation limit for port 0.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (!rst) begin
            case (state_q)
                ARB: begin
                    lock_cnt_d = 3'd0;
                    if (p0_req && p1_req) begin
                        gnt0 = p0_wins;
                        gnt1 = !p0_wins;
                    end else begin
                        gnt0 = p0_req;
                        gnt1 = p1_req;
                    end
                    if (gnt1 && p1_lock) begin
                        state_d = LOCK1;
                    end
                end
                LOCK1: begin
                    gnt1 = p1_req;
                    if (!p1_lock) begin
                        state_d    = ARB;
                        lock_cnt_d = 3'd0;
                    end else if (p0_req) begin
                        if (lock_cnt_q + 3'd1 == LOCK_LIMIT) begin
                            state_d    = ARB;
                            lock_cnt_d = 3'd0;
                        end else begin
                            lock_cnt_d = lock_cnt_q + 3'd1;
                        end
                    end else begin
                        lock_cnt_d = 3'd0;
                    end
                end
            endcase
        end
    end

    assign any_gnt    = gnt0 | gnt1;
    assign sel_we     = gnt1 ? p1_we     : p0_we;
    assign sel_funct3 = gnt1 ? p1_funct3 : p0_funct3;
    assign sel_addr   = gnt1 ? p1_addr   : p0_addr;
    assign sel_wdata  = gnt1 ? p1_wdata  : p0_wdata;

    always_comb begin
        misaligned = 1'b0;
        case (sel_funct3)
            3'b001, 3'b101:         misaligned = sel_addr[0];
            3'b010:                 misaligned = (sel_addr[1:0] != 2'b00);
            3'b011, 3'b110, 3'b111: misaligned = 1'b1;
            default:                misaligned = 1'b0;
        endcase
    end

    assign resp_data = (sel_we || misaligned) ? '0 : mem_rd_data;

    // Memory command holds its last driven value between grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (any_gnt) begin
            funct3_q <= sel_funct3;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rvalid_q <= 1'b0;
            p1_err_q    <= 1'b0;
            p1_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= gnt0;
            p0_err_q    <= gnt0 & misaligned;
            p1_rvalid_q <= gnt1;
            p1_err_q    <= gnt1 & misaligned;
            if (gnt0) begin
                p0_rdata_q <= resp_data;
            end
            if (gnt1) begin
                p1_rdata_q <= resp_data;
            end
        end
    end

    assign p0_gnt      = gnt0;
    assign p1_gnt      = gnt1;
    assign p0_stall    = p0_req & ~gnt0;
    assign mem_wr_en   = any_gnt & sel_we & ~misaligned;
    assign mem_funct3  = any_gnt ? sel_funct3 : funct3_q;
    assign mem_addr    = any_gnt ? sel_addr   : addr_q;
    assign mem_wr_data = any_gnt ? sel_wdata  : wdata_q;
    assign p0_rvalid   = p0_rvalid_q;
    assign p0_err      = p0_err_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rvalid   = p1_rvalid_q;
    assign p1_err      = p1_err_q;
    assign p1_rdata    = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_init = 1'b0;
    logic          p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [2:0]    p0_funct3, p1_funct3;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_stall, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_wr_en;
    logic [2:0]    mem_funct3;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;
    logic [7:0]    env_mem [256];
    logic [7:0]    ref_mem [256];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_stall(p0_stall), .p0_rvalid(p0_rvalid), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_funct3(p1_funct3), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    // Little-endian word w holds the bytes starting at the access address.
    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b010:  return w;
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        return (sz == 0) || ((int'(a[1:0]) % sz) != 0);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[8'(a[7:0] + 8'd3)], ref_mem[8'(a[7:0] + 8'd2)],
                ref_mem[8'(a[7:0] + 8'd1)], ref_mem[a[7:0]]};
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        for (int b = 0; b < size_of(f3); b++) ref_mem[8'(a[7:0] + 8'(b))] = d[8*b +: 8];
    endtask

    assign mem_rd_data = load_val(mem_funct3, {env_mem[8'(mem_addr[7:0] + 8'd3)], env_mem[8'(mem_addr[7:0] + 8'd2)],
                                               env_mem[8'(mem_addr[7:0] + 8'd1)], env_mem[mem_addr[7:0]]});

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= 8'(i * 37 + 11);
        end else if (mem_wr_en) begin
            env_mem[mem_addr[7:0]] <= mem_wr_data[7:0];
            if (mem_funct3[1:0] != 2'b00) env_mem[8'(mem_addr[7:0] + 8'd1)] <= mem_wr_data[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                env_mem[8'(mem_addr[7:0] + 8'd2)] <= mem_wr_data[23:16];
                env_mem[8'(mem_addr[7:0] + 8'd3)] <= mem_wr_data[31:24];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        p0_req = req; p0_we = we; p0_funct3 = f3; p0_addr = a; p0_wdata = d;
    endtask

    task automatic drive1(input logic req, input logic we, input logic lk, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
        p1_req = req; p1_we = we; p1_lock = lk; p1_funct3 = f3; p1_addr = a; p1_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1;
        drive0(1'b1, 1'b1, 3'b010, 32'h10, 32'h55);
        drive1(1'b1, 1'b1, 1'b1, 3'b010, 32'h20, 32'h66);
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt, mem_wr_en} !== 3'b000) begin
            errors++; $display("FAIL reset_gnt got %b want 000", {p0_gnt, p1_gnt, mem_wr_en});
        end
        checks++;
        if (p0_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b want 1", p0_stall); end
        checks++;
        if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== 4'b0000 || p0_rdata !== 32'd0 || p1_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_resp got %b %h %h want 0000 0 0", {p0_rvalid, p0_err, p1_rvalid, p1_err}, p0_rdata, p1_rdata);
        end
        checks++;
        if (mem_addr !== 32'd0 || mem_funct3 !== 3'd0 || mem_wr_data !== 32'd0) begin
            errors++; $display("FAIL reset_mem got %h %h %h want 0 0 0", mem_addr, mem_funct3, mem_wr_data);
        end
        mem_init = 1'b0;
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_store_load();
        rst = 1'b0;
        drive0(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if ({p0_gnt, mem_wr_en} !== 2'b11 || mem_addr !== 32'h10 || mem_wr_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_issue got %b %h %h want 11 10 deadbeef", {p0_gnt, mem_wr_en}, mem_addr, mem_wr_data);
        end
        tick();
        drive0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++;
        if ({p0_rvalid, p0_err} !== 2'b10 || p0_rdata !== 32'd0) begin
            errors++; $display("FAIL sw_resp got %b %h want 10 0", {p0_rvalid, p0_err}, p0_rdata);
        end
        @(negedge clk);
        checks++;
        if ({p0_gnt, mem_wr_en} !== 2'b10) begin errors++; $display("FAIL lw_issue got %b want 10", {p0_gnt, mem_wr_en}); end
        tick();
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checks++;
        if ({p0_rvalid, p0_err} !== 2'b10 || p0_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_resp got %b %h want 10 deadbeef", {p0_rvalid, p0_err}, p0_rdata);
        end
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b0 || mem_addr !== 32'h10) begin
            errors++; $display("FAIL idle_hold got %b %h want 0 10", mem_wr_en, mem_addr);
        end
        tick();
        checks++;
        if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_one_cycle got %b want 0", p0_rvalid); end
    endtask

    task automatic test_conflict();
        logic [1:0] want;
        rst = 1'b1; tick(); rst = 1'b0;
        drive0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL conflict_first got %b want 10", {p0_gnt, p1_gnt}); end
        tick();
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b01 || p0_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL conflict_second got %b %h want 01 deadbeef", {p0_gnt, p1_gnt}, p0_rdata);
        end
        tick();
        checks++;
        if ({p0_rvalid, p1_rvalid} !== 2'b01 || p1_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL conflict_p1_resp got %b %h want 01 deadbeef", {p0_rvalid, p1_rvalid}, p1_rdata);
        end
        drive0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            want = 2'b10;
`endif
            @(negedge clk);
            checks++;
            if ({p0_gnt, p1_gnt} !== want) begin
                errors++; $display("FAIL conflict_seq%0d got %b want %b", i, {p0_gnt, p1_gnt}, want);
            end
            tick();
        end
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_lock_release();
        drive1(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        checks++;
        if (p1_gnt !== 1'b1) begin errors++; $display("FAIL lock_enter got %b want 1", p1_gnt); end
        tick();
        drive0(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) drive1(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            @(negedge clk);
            checks++;
            if ({p0_gnt, p0_stall, p1_gnt} !== {2'b01, i != 2}) begin
                errors++; $display("FAIL lock_hold%0d got %b want %b", i, {p0_gnt, p0_stall, p1_gnt}, {2'b01, i != 2});
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({p0_gnt, p0_stall} !== 2'b10) begin errors++; $display("FAIL lock_release got %b want 10", {p0_gnt, p0_stall}); end
        tick();
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_lock_timeout();
        drive1(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
        tick();
        drive0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            checks++;
            if ({p0_gnt, p1_gnt} !== 2'b01) begin errors++; $display("FAIL timeout_locked%0d got %b want 01", i, {p0_gnt, p1_gnt}); end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt, p0_stall} !== 3'b100) begin
            errors++; $display("FAIL timeout_force got %b want 100", {p0_gnt, p1_gnt, p0_stall});
        end
        tick();
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({p0_rvalid, p0_rdata, p1_gnt} !== {1'b1, 32'hDEADBEEF, 1'b1}) begin
            errors++; $display("FAIL timeout_after got %b %h %b want 1 deadbeef 1", p0_rvalid, p0_rdata, p1_gnt);
        end
        tick();
        drive1(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_misaligned();
        drive0(1'b1, 1'b1, 3'b010, 32'h10, 32'h11223344);
        tick();
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive1(1'b1, 1'b1, 1'b0, 3'b001, 32'h13, 32'h0000BEEF);
        @(negedge clk);
        checks++;
        if ({p1_gnt, mem_wr_en} !== 2'b10) begin errors++; $display("FAIL sh_mis_issue got %b want 10", {p1_gnt, mem_wr_en}); end
        tick();
        drive1(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++;
        if ({p1_rvalid, p1_err} !== 2'b11 || p1_rdata !== 32'd0) begin
            errors++; $display("FAIL sh_mis_resp got %b %h want 11 0", {p1_rvalid, p1_err}, p1_rdata);
        end
        tick();
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checks++;
        if ({p0_rvalid, p0_err} !== 2'b10 || p0_rdata !== 32'h11223344) begin
            errors++; $display("FAIL sh_mis_mem got %b %h want 10 11223344", {p0_rvalid, p0_err}, p0_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        checks++;
        if (p0_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %b want 1", p0_gnt); end
        rst = 1'b1;
        #1;
        checks++;
        if ({p0_gnt, p1_gnt, mem_wr_en} !== 3'b000) begin
            errors++; $display("FAIL rstmid_comb got %b want 000", {p0_gnt, p1_gnt, mem_wr_en});
        end
        tick();
        checks++;
        if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== 4'b0000 || p0_rdata !== 32'd0 || mem_addr !== 32'd0) begin
            errors++; $display("FAIL rstmid_drop got %b %h %h want 0000 0 0", {p0_rvalid, p0_err, p1_rvalid, p1_err}, p0_rdata, mem_addr);
        end
        rst = 1'b0;
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        checks++;
        if (p1_gnt !== 1'b1) begin errors++; $display("FAIL rst_release_gnt got %b want 1", p1_gnt); end
        tick();
        drive1(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checks++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h11223344) begin
            errors++; $display("FAIL rst_release_resp got %b %h want 1 11223344", p1_rvalid, p1_rdata);
        end
        tick();
    endtask

    task automatic test_random();
        logic        pend [2];
        logic        r_we [2];
        logic [2:0]  r_f3 [2];
        logic [31:0] r_a [2];
        logic [31:0] r_d [2];
        logic        exp_v [2];
        logic        exp_e [2];
        logic [31:0] exp_d [2];
        logic        lk, locked, p0_was_req, mis, want_wr;
        int          held, favour, g, sz;
        rst = 1'b1; mem_init = 1'b1;
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick(); tick();
        mem_init = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; exp_v[p] = 1'b0; exp_e[p] = 1'b0; exp_d[p] = 32'd0;
            r_we[p] = 1'b0; r_f3[p] = 3'd0; r_a[p] = 32'd0; r_d[p] = 32'd0;
        end
        lk = 1'b0; locked = 1'b0; held = 0; favour = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = (cyc > 5) && ($urandom_range(0, 99) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 99) < 55) begin
                    pend[p] = 1'b1;
                    r_we[p] = 1'($urandom_range(0, 1));
                    r_d[p]  = $urandom;
                    if ($urandom_range(0, 7) == 0) begin
                        r_f3[p] = 3'($urandom_range(0, 7));
                        r_a[p]  = $urandom;
                    end else begin
                        sz      = $urandom_range(0, 2);
                        r_f3[p] = (sz == 2) ? 3'b010 : 3'(sz + 4 * $urandom_range(0, 1));
                        r_a[p]  = $urandom & ~((32'd1 << sz) - 32'd1);
                    end
                end
            end
            if ($urandom_range(0, 5) == 0) lk = !lk;
            drive0(pend[0], r_we[0], r_f3[0], r_a[0], r_d[0]);
            drive1(pend[1], r_we[1], lk, r_f3[1], r_a[1], r_d[1]);

            g = -1;
            if (!rst) begin
                if (locked) g = pend[1] ? 1 : -1;
                else if (pend[0] && pend[1]) g = favour;
                else if (pend[0]) g = 0;
                else if (pend[1]) g = 1;
            end
            mis = 1'b0; want_wr = 1'b0;
            if (g >= 0) begin
                mis     = is_mis(r_f3[g], r_a[g]);
                want_wr = r_we[g] && !mis;
            end

            @(negedge clk);
            checks++;
            if ({p0_gnt, p1_gnt, p0_stall, mem_wr_en} !== {g == 0, g == 1, pend[0] && g != 0, want_wr}) begin
                errors++; $display("FAIL rnd_gnt cyc %0d got %b want %b", cyc, {p0_gnt, p1_gnt, p0_stall, mem_wr_en},
                                   {g == 0, g == 1, pend[0] && g != 0, want_wr});
            end
            if (g >= 0) begin
                checks++;
                if (mem_addr !== r_a[g] || mem_funct3 !== r_f3[g] || (r_we[g] && mem_wr_data !== r_d[g])) begin
                    errors++; $display("FAIL rnd_cmd cyc %0d got %h %h %h want %h %h %h", cyc, mem_addr, mem_funct3, mem_wr_data,
                                       r_a[g], r_f3[g], r_d[g]);
                end
            end
            checks++;
            if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== {exp_v[0], exp_e[0], exp_v[1], exp_e[1]} ||
                (exp_v[0] && p0_rdata !== exp_d[0]) || (exp_v[1] && p1_rdata !== exp_d[1])) begin
                errors++; $display("FAIL rnd_resp cyc %0d got %b %h %h want %b %h %h", cyc, {p0_rvalid, p0_err, p1_rvalid, p1_err},
                                   p0_rdata, p1_rdata, {exp_v[0], exp_e[0], exp_v[1], exp_e[1]}, exp_d[0], exp_d[1]);
            end

            p0_was_req = pend[0];
            exp_v[0] = 1'b0; exp_e[0] = 1'b0; exp_v[1] = 1'b0; exp_e[1] = 1'b0;
            if (rst) begin
                locked = 1'b0; held = 0; favour = 0;
            end else begin
                if (g >= 0) begin
                    exp_v[g] = 1'b1;
                    exp_e[g] = mis;
                    exp_d[g] = (r_we[g] || mis) ? 32'd0 : load_val(r_f3[g], ref_word(r_a[g]));
                    if (want_wr) ref_store(r_f3[g], r_a[g], r_d[g]);
                    pend[g] = 1'b0;
`ifdef DMEM_ARB_RR_EN
                    favour = 1 - g;
`endif
                end
                if (!locked) begin
                    if (g == 1 && lk) begin locked = 1'b1; held = 0; end
                end else if (!lk) begin
                    locked = 1'b0; held = 0;
                end else if (p0_was_req) begin
                    held++;
                    if (held == 7) begin locked = 1'b0; held = 0; end
                end else begin
                    held = 0;
                end
            end
            tick();
        end
        rst = 1'b0;
        drive0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_conflict();
        test_lock_release();
        test_lock_timeout();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width on all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width on all ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 p0_req, p0_we  input  1 each  core MEM-stage access request and write flag.
REQ-006 p0_funct3  input  3  access size/sign code; p0_addr  input  ADDR_WIDTH; p0_wdata  input  DATA_WIDTH.
REQ-007 p0_gnt  output  1  port-0 access accepted this cycle; p0_stall  output  1  equals p0_req AND NOT p0_gnt.
REQ-008 p0_rvalid, p0_err  output  1 each; p0_rdata  output  DATA_WIDTH  registered response.
REQ-009 p1_req, p1_we, p1_lock  input  1 each  secondary (loader/debug) request, write flag, ownership-hold request.
REQ-010 p1_funct3  input  3; p1_addr  input  ADDR_WIDTH; p1_wdata  input  DATA_WIDTH.
REQ-011 p1_gnt, p1_rvalid, p1_err  output  1 each; p1_rdata  output  DATA_WIDTH.
REQ-012 mem_wr_en  output  1; mem_funct3  output  3; mem_addr  output  ADDR_WIDTH; mem_wr_data  output  DATA_WIDTH  to data memory.
REQ-013 mem_rd_data  input  DATA_WIDTH  combinational read data from data memory for current mem_addr/mem_funct3.

Function
REQ-014 At most one of p0_gnt/p1_gnt SHALL be high in any cycle; gnt is combinational from req and arbiter state.
REQ-015 Granted port's funct3/addr/wdata SHALL drive mem_* in the grant cycle; with no grant, mem_wr_en=0 and mem_* hold last driven values.
REQ-016 mem_wr_en SHALL equal granted we AND NOT misaligned; write commits at the edge ending the grant cycle.
REQ-017 Misaligned: funct3 in {001,101} with addr[0]=1; funct3=010 with addr[1:0]!=00; funct3 in {011,110,111}.
REQ-018 For every grant in cycle N, the granted port SHALL see rvalid=1 for exactly cycle N+1, rdata=mem_rd_data sampled in N (0 for writes or errors), err=misaligned flag from N.
REQ-019 States: ARB, LOCK1. ARB -> LOCK1 when p1 granted with p1_lock=1; LOCK1 -> ARB when p1_lock=0 sampled at an edge.
REQ-020 In LOCK1, p1_gnt=p1_req and p0_gnt=0 regardless of p0_req; p1_lock without p1_req keeps LOCK1 with no access.
REQ-021 In ARB, single requester SHALL be granted immediately (zero wait).
REQ-022 Simultaneous p0_req and p1_req in ARB resolve per REQ-029/REQ-030; the loser keeps req asserted and is granted no later than the next ARB cycle unless LOCK1 entered.
REQ-023 Requester SHALL hold req, we, funct3, addr, wdata stable until gnt; arbiter behaviour on changes before gnt is undefined.
REQ-024 A 3-bit lock-hold counter SHALL count consecutive LOCK1 cycles with p0_req=1; at 7 it forces LOCK1 -> ARB and grants p0 next cycle; counter clears on leaving LOCK1.

Reset
REQ-025 rst=1 SHALL force state ARB, last_gnt=1 (port 0 favoured first), lock counter 0, all rvalid/err 0, all rdata 0.
REQ-026 During rst, p0_gnt=p1_gnt=0 and mem_wr_en=0; reset mid-transaction drops the pending response (no rvalid after rst).
REQ-027 mem_addr, mem_funct3, mem_wr_data SHALL reset to 0.
REQ-028 First edge with rst=0 SHALL allow normal arbitration in that cycle.

Configuration
REQ-029 Macro DMEM_ARB_RR_EN defined: round-robin; on conflict grant port not in last_gnt; last_gnt updates on every grant.
REQ-030 DMEM_ARB_RR_EN undefined: fixed priority, port 0 wins every conflict; last_gnt register not instantiated; REQ-022 fairness applies only to port 0.

Verification
REQ-031 p0 sw addr 0x10 data 0xDEADBEEF, then p0 lw 0x10 -> gnt same cycles, p0_rvalid next cycle, p0_rdata=0xDEADBEEF, p0_err=0.
REQ-032 p0 and p1 both lw in cycle N after reset -> p0 gnt in N, p1 gnt in N+1; with DMEM_ARB_RR_EN repeated conflicts alternate p1,p0,p1.
REQ-033 p1 lock=1 for 3 accesses while p0_req held -> p0_stall=1 throughout, p0 granted cycle after p1_lock drops.
REQ-034 p1 lock held 10 cycles with p0_req=1 -> p0_gnt asserted after 7 LOCK1 cycles.
REQ-035 p1 sh addr 0x13 -> mem_wr_en=0, p1_err=1 with p1_rvalid, p1_rdata=0, memory word unchanged.
REQ-036 rst asserted in grant cycle of p0 lw -> no p0_rvalid following; all outputs at reset values.
